// File: rtl/image_rom_reader.sv
// Raster-scans an IMG_W x IMG_H frame out of a ROM whose enable is pipelined 2 clk deep.
// The frame leaves as a valid/ready pixel stream with x/y coordinates and sof/eol/eof markers.
module image_rom_reader #(
    parameter int  IMG_W  = 32,
    parameter int  IMG_H  = 32,
    parameter int  ADDR_W = 10,
    parameter int  DATA_W = 24,
    localparam int XW     = $clog2(IMG_W),
    localparam int YW     = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [XW-1:0]     m_x,
    output logic [YW-1:0]     m_y,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
        logic          eof;
    } tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        tag_t              tag;
    } pix_t;

    state_t            state_r;
    state_t            state_s;
    logic              prime_cnt_r;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [ADDR_W-1:0] rom_addr_s;
    logic [XW-1:0]     x_r;
    logic [XW-1:0]     x_s;
    logic [YW-1:0]     y_r;
    logic [YW-1:0]     y_s;
    logic              rom_en_r;
    logic              rom_en_s;
    logic              busy_r;
    logic              busy_s;
    logic              done_r;
    logic              done_s;
    logic              infl_r;
    tag_t              tag_r;
    tag_t              tag_s;
    logic [1:0]        fifo_cnt_r;
    logic [1:0]        fifo_cnt_s;
    pix_t              head_r;
    pix_t              head_s;
    pix_t              skid_r;
    pix_t              skid_s;
    pix_t              cap_s;
    logic              m_valid_r;
    logic              pop_s;
    logic              eof_pop_s;
    logic              start_ok_s;
    logic              last_s;
    logic [2:0]        occ_s;
    logic              issue_s;

    // Handshake, start qualification and issue decision
    always_comb begin
        pop_s      = m_valid_r & m_ready;
        eof_pop_s  = pop_s & head_r.tag.eof;
        start_ok_s = start & (state_r == IDLE) & ~done_r;
        last_s     = (x_r == X_LAST) & (y_r == Y_LAST);
        // Occupancy the FIFO will have when an address issued now comes back; keeps a slot reserved.
        occ_s      = {1'b0, fifo_cnt_r} + {2'b00, infl_r} - {2'b00, pop_s};
        issue_s    = (state_r == STREAM) & (occ_s < 3'd2);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            prime_cnt_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            prime_cnt_r <= (state_r == PRIME) ? ~prime_cnt_r : 1'b0;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_s = PRIME;
                else            state_s = IDLE;
            end
            PRIME: begin
                if (prime_cnt_r) state_s = STREAM;
                else             state_s = PRIME;
            end
            STREAM: begin
                if (issue_s && last_s) state_s = DRAIN;
                else                   state_s = STREAM;
            end
            DRAIN: begin
                if (eof_pop_s) state_s = IDLE;
                else           state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs, computed one cycle ahead so they leave the block registered
    always_comb begin
        rom_en_s = 1'b0;
        case (state_s)
            IDLE:    rom_en_s = 1'b0;
            PRIME:   rom_en_s = 1'b1;
            STREAM:  rom_en_s = 1'b1;
            DRAIN:   rom_en_s = issue_s;
            default: rom_en_s = 1'b0;
        endcase
        busy_s = (state_s != IDLE);
        done_s = eof_pop_s;
    end

    // Read address and raster position; the last address is held rather than wrapped
    always_comb begin
        rom_addr_s = rom_addr_r;
        x_s        = x_r;
        y_s        = y_r;
        if (state_s == IDLE) begin
            rom_addr_s = {ADDR_W{1'b0}};
            x_s        = {XW{1'b0}};
            y_s        = {YW{1'b0}};
        end else if (issue_s && !last_s) begin
            rom_addr_s = rom_addr_r + ADDR_W'(1);
            if (x_r == X_LAST) begin
                x_s = {XW{1'b0}};
                y_s = y_r + YW'(1);
            end else begin
                x_s = x_r + XW'(1);
                y_s = y_r;
            end
        end else begin
            rom_addr_s = rom_addr_r;
            x_s        = x_r;
            y_s        = y_r;
        end
    end

    // Tag travelling alongside the outstanding ROM read
    always_comb begin
        tag_s = tag_r;
        if (issue_s) begin
            tag_s.x   = x_r;
            tag_s.y   = y_r;
            tag_s.sof = (x_r == {XW{1'b0}}) & (y_r == {YW{1'b0}});
            tag_s.eol = (x_r == X_LAST);
            tag_s.eof = last_s;
        end else begin
            tag_s = tag_r;
        end
    end

    // Two-entry skid FIFO: head drives the stream, skid absorbs the reserved in-flight read
    always_comb begin
        cap_s.data = rom_data;
        cap_s.tag  = tag_r;
        head_s     = head_r;
        skid_s     = skid_r;
        fifo_cnt_s = fifo_cnt_r;
        case (fifo_cnt_r)
            2'd0: begin
                if (infl_r) begin
                    head_s     = cap_s;
                    fifo_cnt_s = 2'd1;
                end else begin
                    fifo_cnt_s = 2'd0;
                end
            end
            2'd1: begin
                case ({infl_r, pop_s})
                    2'b10: begin
                        skid_s     = cap_s;
                        fifo_cnt_s = 2'd2;
                    end
                    2'b11:   head_s     = cap_s;
                    2'b01:   fifo_cnt_s = 2'd0;
                    default: fifo_cnt_s = 2'd1;
                endcase
            end
            2'd2: begin
                if (pop_s) begin
                    head_s = skid_r;
                    if (infl_r) begin
                        skid_s     = cap_s;
                        fifo_cnt_s = 2'd2;
                    end else begin
                        fifo_cnt_s = 2'd1;
                    end
                end else begin
                    fifo_cnt_s = 2'd2;
                end
            end
            default: fifo_cnt_s = 2'd0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_r <= {ADDR_W{1'b0}};
            x_r        <= {XW{1'b0}};
            y_r        <= {YW{1'b0}};
            rom_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            infl_r     <= 1'b0;
            tag_r      <= '{x: {XW{1'b0}}, y: {YW{1'b0}}, sof: 1'b0, eol: 1'b0, eof: 1'b0};
            fifo_cnt_r <= 2'd0;
            head_r     <= {($bits(pix_t)){1'b0}};
            skid_r     <= {($bits(pix_t)){1'b0}};
            m_valid_r  <= 1'b0;
        end else begin
            rom_addr_r <= rom_addr_s;
            x_r        <= x_s;
            y_r        <= y_s;
            rom_en_r   <= rom_en_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            infl_r     <= issue_s;
            tag_r      <= tag_s;
            fifo_cnt_r <= fifo_cnt_s;
            head_r     <= head_s;
            skid_r     <= skid_s;
            m_valid_r  <= (fifo_cnt_s != 2'd0);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rom_en   = rom_en_r;
    assign rom_addr = rom_addr_r;
    assign m_valid  = m_valid_r;
    assign m_data   = head_r.data;
    assign m_x      = head_r.tag.x;
    assign m_y      = head_r.tag.y;
    assign m_sof    = head_r.tag.sof;
    assign m_eol    = head_r.tag.eol;
    assign m_eof    = head_r.tag.eof;

endmodule

// File: tb/tb_image_rom_reader.sv
// Scoreboard bench for image_rom_reader: a ROM model feeds the reader and every
// presented pixel is compared with the head of an expected-pixel queue.
module tb_image_rom_reader;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 24;
    localparam int NPIX   = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              m_ready = 1'b0;
    logic              busy, done, rom_en, m_valid, m_sof, m_eol, m_eof;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] m_data;
    logic [4:0]        m_x, m_y;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                x;
        int                y;
        logic              sof;
        logic              eol;
        logic              eof;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [DATA_W-1:0] mem [NPIX];
    logic [1:0]        en_p;
    int                n_checks = 0;
    int                n_errors = 0;
    int                hs_cnt = 0;
    int                cyc = 0;
    int                first_cyc = 0;
    int                last_cyc = 0;
    bit                mon_en = 1'b0;
    bit                done_exp = 1'b0;
    bit                frame_done = 1'b0;
    bit                eof_seen = 1'b0;

    image_rom_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_x(m_x), .m_y(m_y),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM: data appears after the edge that samples the address, once en has been high 2 clk
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            en_p     <= 2'b00;
            rom_data <= 24'h000000;
        end else begin
            en_p <= {en_p[0], rom_en};
            if (rom_en && en_p == 2'b11) rom_data <= mem[rom_addr];
            else                         rom_data <= 24'hBADBAD;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"},     32'(busy),     32'd0);
        check_eq({tag, "_done"},     32'(done),     32'd0);
        check_eq({tag, "_rom_en"},   32'(rom_en),   32'd0);
        check_eq({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_eq({tag, "_m_valid"},  32'(m_valid),  32'd0);
        check_eq({tag, "_m_data"},   32'(m_data),   32'd0);
        check_eq({tag, "_m_x"},      32'(m_x),      32'd0);
        check_eq({tag, "_m_y"},      32'(m_y),      32'd0);
        check_eq({tag, "_m_sof"},    32'(m_sof),    32'd0);
        check_eq({tag, "_m_eol"},    32'(m_eol),    32'd0);
        check_eq({tag, "_m_eof"},    32'(m_eof),    32'd0);
    endtask

    // Pulse start for one clock and load the expected frame into the scoreboard
    task automatic start_frame();
        exp_t e;
        @(posedge clk);
        #1;
        for (int a = 0; a < NPIX; a++) begin
            e.data = mem[a];
            e.x    = a % IMG_W;
            e.y    = a / IMG_W;
            e.sof  = (a == 0);
            e.eol  = ((a % IMG_W) == IMG_W - 1);
            e.eof  = (a == NPIX - 1);
            exp_q.push_back(e);
        end
        hs_cnt     = 0;
        frame_done = 1'b0;
        eof_seen   = 1'b0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while (hs_cnt < n && k < 5000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("reach_pixel", 32'(hs_cnt >= n), 32'd1);
    endtask

    task automatic wait_frame(input int budget);
        int k = 0;
        while (!frame_done && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("frame_done",   32'(frame_done),   32'd1);
        check_eq("handshakes",   32'(hs_cnt),       32'(NPIX));
        check_eq("sb_empty",     32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare the presented pixel to the scoreboard head every cycle it is valid
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_eq("done_pulse", 32'(done), 32'(done_exp));
                if (done_exp) begin
                    check_eq("busy_at_done", 32'(busy), 32'd0);
                    frame_done = 1'b1;
                end
                done_exp = 1'b0;
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("valid_unexpected", 32'(m_valid), 32'd0);
                    end else begin
                        mon_e = exp_q[0];
                        check_eq("m_data", 32'(m_data), 32'(mon_e.data));
                        check_eq("m_x",    32'(m_x),    32'(mon_e.x));
                        check_eq("m_y",    32'(m_y),    32'(mon_e.y));
                        check_eq("m_sof",  32'(m_sof),  32'(mon_e.sof));
                        check_eq("m_eol",  32'(m_eol),  32'(mon_e.eol));
                        check_eq("m_eof",  32'(m_eof),  32'(mon_e.eof));
                        if (m_ready) begin
                            void'(exp_q.pop_front());
                            if (hs_cnt == 0) first_cyc = cyc;
                            hs_cnt++;
                            if (mon_e.eof) begin
                                last_cyc = cyc;
                                done_exp = 1'b1;
                                eof_seen = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = DATA_W'($urandom);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        // Full-rate frame: first valid 4 clk after the start edge, then one pixel per clock
        m_ready = 1'b1;
        start_frame();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check_eq("first_valid_lat", 32'(m_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        wait_frame(1200);
        check_eq("stream_span", 32'(last_cyc - first_cyc), 32'(NPIX - 1));

        // Ready toggling every clock
        start_frame();
        begin
            int k = 0;
            while (!frame_done && k < 4000) begin
                @(posedge clk);
                #1;
                m_ready = ~m_ready;
                k++;
            end
        end
        wait_frame(10);
        m_ready = 1'b1;

        // Long stall with pixel 5 at the head
        start_frame();
        wait_hs(5);
        m_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("stall_rom_addr", 32'(rom_addr), 32'd7);
        check_eq("stall_valid",    32'(m_valid),  32'd1);
        check_eq("stall_busy",     32'(busy),     32'd1);
        m_ready = 1'b1;
        wait_frame(1200);

        // Start while busy, then start coinciding with done, both ignored
        start_frame();
        wait_hs(100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int k = 0;
            while (!eof_seen && k < 2000) begin
                @(posedge clk);
                k++;
            end
        end
        #1;
        check_eq("done_cycle", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("idle_busy",   32'(busy),    32'd0);
            check_eq("idle_valid",  32'(m_valid), 32'd0);
            check_eq("idle_rom_en", 32'(rom_en),  32'd0);
            @(posedge clk);
            #1;
        end
        check_eq("frame_done_t5", 32'(frame_done), 32'd1);
        check_eq("handshakes_t5", 32'(hs_cnt),     32'(NPIX));

        // Reset mid-frame, then a clean restart from pixel 0
        start_frame();
        wait_hs(300);
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_zero("abort");
        exp_q.delete();
        done_exp = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        start_frame();
        wait_frame(1200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
